// File: rtl/fp_buf_pkg.sv
// Shared types and bf16 lane constants for the fp weight buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_buf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      READY  = 2'd2,
      STREAM = 2'd3
   } state_t;

   localparam int BF16_W     = 16;
   localparam int DATA_W_DEF = 256;
   localparam int LANES      = DATA_W_DEF / BF16_W;

   // Number of bf16 lanes packed in a channel word of the given width.
   function automatic int lanes_of(input int data_w);
      return data_w / BF16_W;
   endfunction

endpackage

// File: rtl/fp_buf_bank.sv
// One channel of weight storage: DEPTH x DATA_W RAM, one write port, one read port.
// Latency: read data appears on o_rd_dat one cycle after i_rd_en.
// Backpressure: o_rd_dat holds its value whenever i_rd_en is low.
module fp_buf_bank #(
   parameter int DATA_W = 256,
   parameter int DEPTH  = 64,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_dat,
   input  logic              i_rd_en,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [DATA_W-1:0] o_rd_dat
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_dat;

   // Storage array; contents survive reset on purpose (only stored_len is cleared).
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_dat;
      end
   end

   // Registered read doubling as the output register; holds while not enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_dat <= '0;
      end else if (i_rd_en) begin
         r_rd_dat <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/fp_weight_buffer.sv
// Per-PE bf16 weight store: framed load of up to DEPTH vectors, replayed N passes to the MAC array.
// Latency: first vector valid one cycle after stream_start, then one vector per cycle.
// Backpressure: wr_ready drops when full; output holds all fields while out_valid && !out_ready.
module fp_weight_buffer
   import fp_buf_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int DEPTH  = 64,
   parameter int NUM_CH = 4,
   parameter int REP_W  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load_start,
   input  logic                       load_done,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [NUM_CH*DATA_W-1:0]   wr_data,
   input  logic                       stream_start,
   input  logic [REP_W-1:0]           replay_cnt,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_CH*DATA_W-1:0]   out_data,
   output logic                       out_last,
   output logic                       out_final,
   output logic [$clog2(DEPTH):0]     stored_len,
   output logic                       busy,
   output logic                       err
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LEN_W = AW + 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LEN_W-1:0]  r_len;
   logic [REP_W-1:0]  r_pass;
   logic [REP_W-1:0]  r_passes;
   logic              r_out_valid;
   logic              r_out_last;
   logic              r_out_final;
   logic              r_issued_all;
   logic              r_err;

   logic              w_full;
   logic              w_wr_fire;
   logic              w_start;
   logic              w_rd_en;
   logic              w_out_fire;
   logic [AW-1:0]     w_rd_ptr;
   logic [REP_W-1:0]  w_pass;
   logic [REP_W-1:0]  w_passes;
   logic              w_is_last;
   logic              w_is_final;
   logic [LEN_W-1:0]  w_len_after;
   logic              w_err_set;

   assign w_full      = (r_len == LEN_W'(DEPTH));
   assign wr_ready    = (r_state == LOAD) && !w_full;
   // load_start clears the store this cycle, so a coincident write is dropped.
   assign w_wr_fire   = wr_ready && wr_valid && !load_start;
   assign w_len_after = r_len + LEN_W'(w_wr_fire);
   assign w_out_fire  = r_out_valid && out_ready;

   // stream_start issues the read of word 0 directly so it is valid the next cycle.
   assign w_start  = (r_state == READY) && stream_start && !load_start;
   assign w_rd_en  = !load_start &&
                     (w_start || ((r_state == STREAM) && !r_issued_all &&
                                  (!r_out_valid || out_ready)));
   assign w_rd_ptr = w_start ? '0 : r_rd_ptr;
   assign w_pass   = w_start ? REP_W'(1) : r_pass;
   assign w_passes = w_start ? ((replay_cnt == '0) ? REP_W'(1) : replay_cnt) : r_passes;

   assign w_is_last  = ({1'b0, w_rd_ptr} == (r_len - LEN_W'(1)));
   assign w_is_final = w_is_last && (w_pass == w_passes);

   // Protocol violations; anything overridden by load_start is not an error.
   assign w_err_set = (wr_valid && (r_state != LOAD)) ||
                      (!load_start && stream_start && (r_state != READY)) ||
                      (!load_start && load_done && (r_state != LOAD));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; load_start overrides everything else.
   always_comb begin
      w_state_nxt = r_state;
      if (load_start) begin
         w_state_nxt = LOAD;
      end else begin
         unique case (r_state)
            IDLE:   w_state_nxt = IDLE;
            LOAD:   if (load_done) w_state_nxt = (w_len_after != '0) ? READY : IDLE;
            READY:  if (stream_start) w_state_nxt = STREAM;
            STREAM: if (w_out_fire && r_out_final) w_state_nxt = READY;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Write pointer, fill count, read pointer, pass counter and output flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_len        <= '0;
         r_rd_ptr     <= '0;
         r_pass       <= '0;
         r_passes     <= '0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_final  <= 1'b0;
         r_issued_all <= 1'b0;
      end else if (load_start) begin
         r_wr_ptr     <= '0;
         r_len        <= '0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_final  <= 1'b0;
         r_issued_all <= 1'b0;
      end else begin
         if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_len    <= w_len_after;
         end
         if (w_start) begin
            r_passes     <= w_passes;
            r_issued_all <= 1'b0;
         end
         if (w_rd_en) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_is_last;
            r_out_final <= w_is_final;
            if (w_is_last) begin
               r_rd_ptr <= '0;
               r_pass   <= w_pass + REP_W'(1);
            end else begin
               r_rd_ptr <= w_rd_ptr + AW'(1);
               r_pass   <= w_pass;
            end
            if (w_is_final) begin
               r_issued_all <= 1'b1;
            end
         end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_final <= 1'b0;
         end
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end

   // One bank per channel, all sharing address and enables.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
      fp_buf_bank #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .AW     (AW)
      ) u_bank (
         .clk       (clk),
         .reset     (reset),
         .i_wr_en   (w_wr_fire),
         .i_wr_addr (r_wr_ptr),
         .i_wr_dat  (wr_data[g*DATA_W +: DATA_W]),
         .i_rd_en   (w_rd_en),
         .i_rd_addr (w_rd_ptr),
         .o_rd_dat  (out_data[g*DATA_W +: DATA_W])
      );
   end

   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign out_final  = r_out_final;
   assign stored_len = r_len;
   assign busy       = (r_state == LOAD) || (r_state == STREAM);
   assign err        = r_err;

endmodule

// File: tb/tb_fp_weight_buffer.sv
// Self-checking bench for fp_weight_buffer with a scoreboard of expected output vectors.
// Latency: expects first vector one cycle after stream_start, one per cycle thereafter.
// Backpressure: drives out_ready patterns and checks output stability while stalled.
module tb_fp_weight_buffer;

   localparam int DATA_W = 256;
   localparam int DEPTH  = 64;
   localparam int NUM_CH = 4;
   localparam int REP_W  = 8;
   localparam int VW     = NUM_CH * DATA_W;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic             clk;
   logic             reset;
   logic             load_start;
   logic             load_done;
   logic             wr_valid;
   logic             wr_ready;
   logic [VW-1:0]    wr_data;
   logic             stream_start;
   logic [REP_W-1:0] replay_cnt;
   logic             out_valid;
   logic             out_ready;
   logic [VW-1:0]    out_data;
   logic             out_last;
   logic             out_final;
   logic [LW-1:0]    stored_len;
   logic             busy;
   logic             err;

   typedef struct {
      logic [VW-1:0] d;
      logic          l;
      logic          f;
   } exp_t;

   exp_t          exp_q[$];
   logic [VW-1:0] mem_m [DEPTH];
   int            n_stored = 0;
   int            total    = 0;
   int            bad      = 0;
   int            acc;

   fp_weight_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .NUM_CH (NUM_CH),
      .REP_W  (REP_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load_start   (load_start),
      .load_done    (load_done),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .stream_start (stream_start),
      .replay_cnt   (replay_cnt),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_final    (out_final),
      .stored_len   (stored_len),
      .busy         (busy),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      int idx;
      idx = 0;
      total++;
      if (got !== exp) begin
         bad++;
         for (int i = VW/64 - 1; i >= 0; i--) begin
            if (got[i*64 +: 64] !== exp[i*64 +: 64]) idx = i;
         end
         $display("FAIL %s word%0d got=%h exp=%h", tag, idx, got[idx*64 +: 64], exp[idx*64 +: 64]);
      end
   endtask

   function automatic logic [VW-1:0] mkvec(input int s);
      logic [VW-1:0] v;
      logic [31:0]   w;
      v = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w = 32'(s * 16 + c) ^ 32'hA5A5_0000;
         v[c*DATA_W +: DATA_W] = {8{w}};
      end
      return v;
   endfunction

   // Output monitor: scoreboard pop on handshake, stability check while stalled.
   logic          prev_stall = 1'b0;
   logic [VW-1:0] prev_d;
   logic          prev_l;
   logic          prev_f;
   always @(negedge clk) begin : mon
      exp_t e;
      if (prev_stall && out_valid) begin
         chk("hold_data", out_data, prev_d);
         chk("hold_last", out_last, prev_l);
         chk("hold_final", out_final, prev_f);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("extra_out", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_last", out_last, e.l);
            chk("out_final", out_final, e.f);
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
      prev_f     = out_final;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      load_start   = 1'b0;
      load_done    = 1'b0;
      wr_valid     = 1'b0;
      wr_data      = '0;
      stream_start = 1'b0;
      replay_cnt   = '0;
      out_ready    = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      exp_q.delete();
      n_stored = 0;
   endtask

   // Frame a load offering n_offer vectors back to back; mirrors accepted data.
   task automatic load(input int n_offer, input int seed, output int n_acc);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      n_acc = 0;
      for (int k = 0; k < n_offer; k++) begin
         wr_valid = 1'b1;
         wr_data  = mkvec(seed + k);
         if (wr_ready && n_acc < DEPTH) begin
            mem_m[n_acc] = wr_data;
            n_acc++;
         end
         tick();
      end
      wr_valid  = 1'b0;
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      n_stored  = n_acc;
   endtask

   // Replay the stored set; bp selects the 1,0,0,1 out_ready pattern.
   task automatic run_stream(input int rep, input bit bp, input string tag);
      int passes;
      int cyc;
      passes = (rep == 0) ? 1 : rep;
      cyc    = 0;
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < n_stored; i++) begin
            exp_q.push_back('{d: mem_m[i], l: (i == n_stored - 1),
                              f: ((i == n_stored - 1) && (p == passes - 1))});
         end
      end
      out_ready    = 1'b1;
      replay_cnt   = REP_W'(rep);
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      chk({tag, "_first_lat"}, out_valid, 1);
      while (exp_q.size() > 0 && cyc < 2000) begin
         out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         tick();
         cyc++;
      end
      if (exp_q.size() > 0) begin
         chk({tag, "_timeout"}, 1, 0);
         exp_q.delete();
      end else if (!bp) begin
         chk({tag, "_cycles"}, cyc, passes * n_stored);
      end
      chk({tag, "_end_vld"}, out_valid, 0);
      chk({tag, "_end_busy"}, busy, 0);
      out_ready = 1'b1;
      tick();
      chk({tag, "_ready_len"}, stored_len, n_stored);
   endtask

   initial begin
      do_reset();
      chk("rst_valid", out_valid, 0);
      chk("rst_len", stored_len, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_last", out_last, 0);
      chk("rst_final", out_final, 0);
      chk("rst_data", out_data, 0);

      // Basic: three vectors, two passes.
      load(3, 100, acc);
      chk("basic_acc", acc, 3);
      chk("basic_len", stored_len, 3);
      chk("basic_ready_state", busy, 0);
      run_stream(2, 1'b0, "basic");

      // Full buffer: 70 offered, 64 accepted, then streamed under backpressure.
      load(70, 1000, acc);
      chk("full_acc", acc, DEPTH);
      chk("full_len", stored_len, DEPTH);
      chk("full_wr_ready", wr_ready, 0);
      chk("full_err", err, 0);
      run_stream(1, 1'b1, "bp");

      // replay_cnt = 0 gives a single pass.
      load(2, 2000, acc);
      chk("rep0_len", stored_len, 2);
      run_stream(0, 1'b0, "rep0");

      // Abort a stream at word 1 with load_start.
      load(4, 3000, acc);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{d: mem_m[i], l: (i == 3), f: (i == 3)});
      end
      out_ready    = 1'b1;
      replay_cnt   = REP_W'(1);
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      tick();
      chk("abort_word1_vld", out_valid, 1);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("abort_expect_2left", exp_q.size(), 2);
      exp_q.delete();
      chk("abort_vld", out_valid, 0);
      chk("abort_len", stored_len, 0);
      chk("abort_busy", busy, 1);
      chk("abort_wr_ready", wr_ready, 1);
      tick();
      chk("abort_vld_hold", out_valid, 0);

      // Empty load returns to IDLE.
      load(0, 0, acc);
      chk("empty_len", stored_len, 0);
      chk("empty_busy", busy, 0);
      chk("empty_err", err, 0);

      // stream_start in IDLE is ignored and flags err.
      replay_cnt   = REP_W'(1);
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      chk("idle_start_err", err, 1);
      chk("idle_start_vld", out_valid, 0);
      chk("idle_start_busy", busy, 0);
      tick();
      chk("idle_start_vld2", out_valid, 0);

      // Reset mid-stream clears count, flags and err.
      load(3, 4000, acc);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{d: mem_m[i], l: (i == 2), f: (i == 2)});
      end
      out_ready    = 1'b1;
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      chk("midrst_len", stored_len, 0);
      chk("midrst_vld", out_valid, 0);
      chk("midrst_err", err, 0);
      chk("midrst_busy", busy, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
